cic_gain_controller: RTL and testbench
======================================

Name: cic_gain_controller

Overview:
- Automatic gain controller (AGC) for the CIC decimator.
- Watches decimated CIC output samples, measures peak magnitude over a window of WINDOW samples, and steps the CIC `gain` port up or down by one.
- Holds the CIC output inside a target amplitude band, with hold-off after each change.
- Manual override passes a software gain straight through.
- Sits between the CIC output (`data_out`/`data_clk`) and the CIC `gain` input.

Parameters:
- DATA_WIDTH, 12, width of signed CIC output sample.
- GAIN_WIDTH, 8, width of gain word.
- GAIN_MIN, 0, lowest gain the controller drives.
- GAIN_MAX, 8, highest gain the controller drives.
- GAIN_INIT, 0, gain after reset.
- WINDOW, 256, decimated samples per measurement window (>=2).
- HOLDOFF_WINDOWS, 2, windows discarded after a gain change (>=1).
- HIGH_THRESHOLD, 1536, peak >= this means step gain down.
- LOW_THRESHOLD, 512, peak < this means step gain up (must be < HIGH_THRESHOLD/2).

Ports:
- clk  in  1  system clock (same clock as the CIC).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = AGC runs; 0 = freeze gain, FSM to IDLE.
- manual  in  1  1 = gain follows gain_manual (clamped).
- gain_manual  in  GAIN_WIDTH  software gain.
- data_clk  in  1  CIC decimated-data clock (square wave, synchronous to clk).
- data_in  in  DATA_WIDTH signed  CIC data_out.
- gain  out  GAIN_WIDTH  registered gain to CIC.
- gain_changed  out  1  one-cycle pulse when gain changes under AGC.
- peak  out  DATA_WIDTH-1  peak magnitude of the last completed window.
- state  out  2  FSM state, for debug.

Behaviour:
- Reset (async, rst_n=0):
  - gain=GAIN_INIT, gain_changed=0, peak=0, state=IDLE.
  - Internal sample count=0, running peak=0, holdoff count=0, data_clk_q=0.
- Sample strobe:
  - strobe = data_clk & ~data_clk_q, where data_clk_q is data_clk registered.
  - data_in is captured on the strobe cycle.
  - If data_clk is already high out of reset, a strobe fires on the first cycle; it is ignored while in IDLE.
- Magnitude:
  - mag = |data_in| in DATA_WIDTH-1 unsigned bits.
  - -2^(DATA_WIDTH-1) saturates to 2^(DATA_WIDTH-1)-1.
- FSM states: IDLE=0, MEASURE=1, UPDATE=2, HOLDOFF=3.
  - IDLE: go to MEASURE when enable=1 and manual=0. Clear count and running peak.
  - MEASURE: on each strobe, running peak=max(running peak, mag) and count+1. On the strobe that completes WINDOW samples (count==WINDOW-1), go to UPDATE next cycle; the final sample is included in the peak.
  - UPDATE (exactly one cycle):
    - peak <= running peak (final value).
    - If final >= HIGH_THRESHOLD and gain>GAIN_MIN: gain-1.
    - Else if final < LOW_THRESHOLD and gain<GAIN_MAX: gain+1.
    - Else gain unchanged.
    - gain register and gain_changed=1 are visible the cycle after UPDATE.
    - Next state: HOLDOFF if gain changed, else MEASURE. Count and running peak are cleared.
  - HOLDOFF: count strobes without measuring; after HOLDOFF_WINDOWS*WINDOW strobes, go to MEASURE. This lets the CIC comb pipeline flush samples taken at the old gain.
- A strobe in the UPDATE cycle counts as the first sample of the following MEASURE or HOLDOFF phase.
- Gain at GAIN_MIN or GAIN_MAX saturates: no change, no pulse, no holdoff.
- manual=1 (priority over enable):
  - gain <= min(max(gain_manual, GAIN_MIN), GAIN_MAX) every cycle.
  - FSM forced to IDLE; gain_changed stays 0.
  - On manual 1->0 with enable=1, measurement restarts from the current gain.
- enable=0 (manual=0): gain held, FSM to IDLE next cycle, and any partial window is discarded. Deasserting mid-window or mid-holdoff abandons it.
- peak holds its value outside UPDATE.

Decomposition:
- Shared package cic_pkg:
  - agc_state_t enum (IDLE, MEASURE, UPDATE, HOLDOFF; 2 bits).
  - Gain word typedef.
  - Default constants.
  - Saturating-abs function.
- One sub-module, cic_peak_detector:
  - Contains the strobe edge detect, abs, running peak and window counter.
  - Interface: clear and enable in; window_done pulse and window_peak out.
  - The FSM, gain register and holdoff live in cic_gain_controller.

Test Plan:
- Bench setup: WINDOW=8, HOLDOFF_WINDOWS=2, data_clk period 16 clk.
- Reset: assert rst_n=0 mid-run -> gain=0, peak=0, state=0 immediately, gain_changed=0.
- Low signal: data_in=+100 constant, gain=3 -> after 8 strobes, peak=100, gain=4, one gain_changed pulse. Then 16 strobes in HOLDOFF with no change, then gain=5 after the next window.
- Overload: gain=5, data_in=-2048 once in a window of zeros -> peak=2047, gain=4 after UPDATE.
- In-band: data_in alternating ±1000 -> peak=1000, gain unchanged, no pulse, no holdoff; the next window starts immediately.
- Saturation:
  - gain=GAIN_MAX=8 and data_in=0 -> gain stays 8, no pulse.
  - gain=0 and data_in=2047 -> gain stays 0.
- Manual:
  - manual=1, gain_manual=200 -> gain=8 next cycle, state=IDLE.
  - Release manual mid-window -> a full 8-sample window is measured before any change.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared types, defaults and helpers for the CIC automatic gain controller.
package cic_pkg;

  localparam int unsigned DEF_DATA_WIDTH      = 12;
  localparam int unsigned DEF_GAIN_WIDTH      = 8;
  localparam int unsigned DEF_GAIN_MIN        = 0;
  localparam int unsigned DEF_GAIN_MAX        = 8;
  localparam int unsigned DEF_GAIN_INIT       = 0;
  localparam int unsigned DEF_WINDOW          = 256;
  localparam int unsigned DEF_HOLDOFF_WINDOWS = 2;
  localparam int unsigned DEF_HIGH_THRESHOLD  = 1536;
  localparam int unsigned DEF_LOW_THRESHOLD   = 512;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    UPDATE  = 2'd2,
    HOLDOFF = 2'd3
  } agc_state_t;

  typedef logic [DEF_GAIN_WIDTH-1:0] gain_t;

  // |x| for a w-bit signed sample, saturating the most negative code to 2^(w-1)-1.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned w);
    logic [31:0] lim;
    logic [31:0] mag;
    lim = (32'd1 << (w - 1)) - 32'd1;
    mag = (x < 0) ? 32'(-x) : 32'(x);
    return (mag > lim) ? lim : mag;
  endfunction

  function automatic int unsigned clamp_u(input int unsigned v, input int unsigned lo,
                                          input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/cic_peak_detector.sv
// Sample strobe detection, magnitude, running window peak and sample counter.
module cic_peak_detector
  import cic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned WINDOW     = DEF_WINDOW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         enable,
  input  logic                         data_clk,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         strobe_c,
  output logic                         window_done_c,
  output logic        [DATA_WIDTH-2:0] window_peak
);

  localparam int unsigned CNT_W = $clog2(WINDOW);
  localparam int unsigned MAG_W = DATA_WIDTH - 1;

  logic             data_clk_q;
  logic [CNT_W-1:0] cnt_q;
  logic [MAG_W-1:0] run_peak_q;
  logic [MAG_W-1:0] mag_c;
  logic [MAG_W-1:0] max_c;
  logic             sample_c;

  assign strobe_c      = data_clk & ~data_clk_q;
  assign sample_c      = strobe_c & enable;
  assign mag_c         = MAG_W'(sat_abs(32'(data_in), DATA_WIDTH));
  assign max_c         = (mag_c > run_peak_q) ? mag_c : run_peak_q;
  assign window_done_c = sample_c && !clear && (cnt_q == CNT_W'(WINDOW - 1));
  assign window_peak   = run_peak_q;

  // A sample arriving with clear starts the next window rather than being lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_clk_q <= 1'b0;
      cnt_q      <= '0;
      run_peak_q <= '0;
    end else begin
      data_clk_q <= data_clk;
      if (clear) begin
        cnt_q      <= sample_c ? CNT_W'(1) : '0;
        run_peak_q <= sample_c ? mag_c : '0;
      end else if (sample_c) begin
        cnt_q      <= window_done_c ? '0 : cnt_q + CNT_W'(1);
        run_peak_q <= max_c;
      end
    end
  end

endmodule

// File: rtl/cic_gain_controller.sv
// AGC for the CIC decimator: windowed peak measurement, one-step gain moves, holdoff.
module cic_gain_controller
  import cic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned GAIN_WIDTH      = DEF_GAIN_WIDTH,
  parameter int unsigned GAIN_MIN        = DEF_GAIN_MIN,
  parameter int unsigned GAIN_MAX        = DEF_GAIN_MAX,
  parameter int unsigned GAIN_INIT       = DEF_GAIN_INIT,
  parameter int unsigned WINDOW          = DEF_WINDOW,
  parameter int unsigned HOLDOFF_WINDOWS = DEF_HOLDOFF_WINDOWS,
  parameter int unsigned HIGH_THRESHOLD  = DEF_HIGH_THRESHOLD,
  parameter int unsigned LOW_THRESHOLD   = DEF_LOW_THRESHOLD
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         manual,
  input  logic        [GAIN_WIDTH-1:0] gain_manual,
  input  logic                         data_clk,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic        [GAIN_WIDTH-1:0] gain,
  output logic                         gain_changed,
  output logic        [DATA_WIDTH-2:0] peak,
  output logic        [1:0]            state
);

  localparam int unsigned HOLD_TOTAL = HOLDOFF_WINDOWS * WINDOW;
  localparam int unsigned HOLD_W     = $clog2(HOLD_TOTAL);
  localparam int unsigned PEAK_W     = DATA_WIDTH - 1;

  agc_state_t        state_q, state_d;
  logic [GAIN_WIDTH-1:0] gain_q, gain_d;
  logic              changed_q, changed_d;
  logic [PEAK_W-1:0] peak_q, peak_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              det_clear_c, det_en_c;
  logic              strobe_c, window_done_c;
  logic [PEAK_W-1:0] window_peak;
  logic              step_down_c, step_up_c;

  cic_peak_detector #(
    .DATA_WIDTH(DATA_WIDTH),
    .WINDOW    (WINDOW)
  ) u_peak (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (det_clear_c),
    .enable       (det_en_c),
    .data_clk     (data_clk),
    .data_in      (data_in),
    .strobe_c     (strobe_c),
    .window_done_c(window_done_c),
    .window_peak  (window_peak)
  );

  assign step_down_c = (32'(window_peak) >= HIGH_THRESHOLD) && (32'(gain_q) > GAIN_MIN);
  assign step_up_c   = (32'(window_peak) < LOW_THRESHOLD) && (32'(gain_q) < GAIN_MAX);

  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    changed_d   = 1'b0;
    peak_d      = peak_q;
    hold_d      = hold_q;
    det_clear_c = 1'b1;
    det_en_c    = 1'b0;
    if (manual) begin
      gain_d  = GAIN_WIDTH'(clamp_u(32'(gain_manual), GAIN_MIN, GAIN_MAX));
      state_d = IDLE;
    end else if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = MEASURE;
        MEASURE: begin
          det_clear_c = 1'b0;
          det_en_c    = 1'b1;
          if (window_done_c) state_d = UPDATE;
        end
        UPDATE: begin
          peak_d = window_peak;
          hold_d = HOLD_W'(strobe_c);
          if (step_down_c) begin
            gain_d    = gain_q - GAIN_WIDTH'(1);
            changed_d = 1'b1;
            state_d   = HOLDOFF;
          end else if (step_up_c) begin
            gain_d    = gain_q + GAIN_WIDTH'(1);
            changed_d = 1'b1;
            state_d   = HOLDOFF;
          end else begin
            det_en_c = 1'b1;
            state_d  = MEASURE;
          end
        end
        HOLDOFF: begin
          // Discard samples still carrying the old gain through the CIC combs.
          if (strobe_c) begin
            if (hold_q == HOLD_W'(HOLD_TOTAL - 1)) begin
              hold_d  = '0;
              state_d = MEASURE;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gain_q    <= GAIN_WIDTH'(GAIN_INIT);
      changed_q <= 1'b0;
      peak_q    <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gain_q    <= gain_d;
      changed_q <= changed_d;
      peak_q    <= peak_d;
      hold_q    <= hold_d;
    end
  end

  assign gain         = gain_q;
  assign gain_changed = changed_q;
  assign peak         = peak_q;
  assign state        = state_q;

endmodule

// File: tb/tb_cic_gain_controller.sv
// Self-checking bench for cic_gain_controller against a per-sample AGC reference model.
`timescale 1ns/1ps
module tb_cic_gain_controller;

  localparam int DW   = 12;
  localparam int GW   = 8;
  localparam int WIN  = 8;
  localparam int HOLD = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 manual = 1'b0;
  logic        [GW-1:0] gain_manual = '0;
  logic                 data_clk = 1'b0;
  logic signed [DW-1:0] data_in = '0;
  logic        [GW-1:0] gain;
  logic                 gain_changed;
  logic        [DW-2:0] peak;
  logic        [1:0]    state;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int m_gain = 0, m_cnt = 0, m_peak = 0, m_hold = 0, m_pulses = 0, m_last_peak = 0;
  bit m_active = 0;

  cic_gain_controller #(
    .DATA_WIDTH(DW), .GAIN_WIDTH(GW), .GAIN_MIN(0), .GAIN_MAX(8), .GAIN_INIT(0),
    .WINDOW(WIN), .HOLDOFF_WINDOWS(HOLD), .HIGH_THRESHOLD(1536), .LOW_THRESHOLD(512)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .manual(manual), .gain_manual(gain_manual),
    .data_clk(data_clk), .data_in(data_in), .gain(gain), .gain_changed(gain_changed),
    .peak(peak), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (8) @(negedge clk);
      data_clk = ~data_clk;
    end
  end

  always @(negedge clk) if (gain_changed === 1'b1) pulse_cnt <= pulse_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: AGC rules applied sample by sample.
  task automatic model_sample(input int v);
    int mag;
    if (!m_active) return;
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    if (m_hold > 0) begin
      m_hold--;
      return;
    end
    if (mag > m_peak) m_peak = mag;
    m_cnt++;
    if (m_cnt == WIN) begin
      m_last_peak = m_peak;
      if (m_peak >= 1536 && m_gain > 0) begin
        m_gain--; m_hold = HOLD * WIN; m_pulses++;
      end else if (m_peak < 512 && m_gain < 8) begin
        m_gain++; m_hold = HOLD * WIN; m_pulses++;
      end
      m_cnt = 0;
      m_peak = 0;
    end
  endtask

  task automatic push(input int v);
    @(negedge data_clk);
    data_in = DW'(v);
    @(posedge data_clk);
    repeat (4) @(negedge clk);
    model_sample(v);
  endtask

  task automatic set_manual(input int g);
    @(negedge clk);
    manual = 1'b1;
    gain_manual = GW'(g);
    repeat (2) @(negedge clk);
    m_active = 0;
    m_gain = (g > 8) ? 8 : g;
  endtask

  task automatic release_run();
    @(posedge data_clk);
    repeat (4) @(negedge clk);
    manual = 1'b0;
    enable = 1'b1;
    m_active = 1;
    m_cnt = 0; m_peak = 0; m_hold = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (gain !== 8'd0) begin failures++; $display("FAIL reset_gain: got %0d expected 0", gain); end
    if (peak !== 11'd0) begin failures++; $display("FAIL reset_peak: got %0d expected 0", peak); end
    if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
    if (gain_changed !== 1'b0) begin failures++; $display("FAIL reset_pulse: got %0b expected 0", gain_changed); end
    rst_n = 1'b1;
  endtask

  task automatic test_low_signal();
    int base;
    set_manual(3);
    release_run();
    base = pulse_cnt;
    for (int i = 0; i < 7; i++) push(100);
    checks++;
    if (gain !== 8'd3) begin failures++; $display("FAIL low_early: got %0d expected 3", gain); end
    push(100);
    checks += 4;
    if (peak !== 11'd100) begin failures++; $display("FAIL low_peak: got %0d expected 100", peak); end
    if (gain !== 8'd4) begin failures++; $display("FAIL low_gain1: got %0d expected 4", gain); end
    if (pulse_cnt - base !== 1) begin failures++; $display("FAIL low_pulse1: got %0d expected 1", pulse_cnt - base); end
    if (state !== 2'd3) begin failures++; $display("FAIL low_holdoff_state: got %0d expected 3", state); end
    for (int i = 0; i < 16; i++) push(100);
    checks += 2;
    if (gain !== 8'd4) begin failures++; $display("FAIL low_holdoff_gain: got %0d expected 4", gain); end
    if (pulse_cnt - base !== 1) begin failures++; $display("FAIL low_holdoff_pulse: got %0d expected 1", pulse_cnt - base); end
    for (int i = 0; i < 8; i++) push(100);
    checks += 2;
    if (gain !== 8'd5) begin failures++; $display("FAIL low_gain2: got %0d expected 5", gain); end
    if (gain !== GW'(m_gain)) begin failures++; $display("FAIL low_model: got %0d expected %0d", gain, m_gain); end
  endtask

  task automatic test_overload();
    int pos;
    pos = int'($urandom_range(0, 7));
    set_manual(5);
    release_run();
    for (int i = 0; i < 8; i++) push((i == pos) ? -2048 : 0);
    checks += 2;
    if (peak !== 11'd2047) begin failures++; $display("FAIL over_peak: got %0d expected 2047", peak); end
    if (gain !== 8'd4) begin failures++; $display("FAIL over_gain: got %0d expected 4", gain); end
  endtask

  task automatic test_inband();
    int base;
    set_manual(4);
    release_run();
    base = pulse_cnt;
    for (int i = 0; i < 8; i++) push((i % 2 == 0) ? 1000 : -1000);
    checks += 4;
    if (peak !== 11'd1000) begin failures++; $display("FAIL inband_peak: got %0d expected 1000", peak); end
    if (gain !== 8'd4) begin failures++; $display("FAIL inband_gain: got %0d expected 4", gain); end
    if (pulse_cnt - base !== 0) begin failures++; $display("FAIL inband_pulse: got %0d expected 0", pulse_cnt - base); end
    if (state !== 2'd1) begin failures++; $display("FAIL inband_state: got %0d expected 1", state); end
    for (int i = 0; i < 8; i++) push(100);
    checks++;
    if (gain !== 8'd5) begin failures++; $display("FAIL inband_next_window: got %0d expected 5", gain); end
  endtask

  task automatic test_saturation();
    int base;
    set_manual(8);
    release_run();
    base = pulse_cnt;
    for (int i = 0; i < 8; i++) push(0);
    checks += 3;
    if (gain !== 8'd8) begin failures++; $display("FAIL sat_max_gain: got %0d expected 8", gain); end
    if (pulse_cnt - base !== 0) begin failures++; $display("FAIL sat_max_pulse: got %0d expected 0", pulse_cnt - base); end
    if (state !== 2'd1) begin failures++; $display("FAIL sat_max_state: got %0d expected 1", state); end
    set_manual(0);
    release_run();
    for (int i = 0; i < 8; i++) push(2047);
    checks += 2;
    if (gain !== 8'd0) begin failures++; $display("FAIL sat_min_gain: got %0d expected 0", gain); end
    if (peak !== 11'd2047) begin failures++; $display("FAIL sat_min_peak: got %0d expected 2047", peak); end
  endtask

  task automatic test_manual();
    set_manual(200);
    checks += 2;
    if (gain !== 8'd8) begin failures++; $display("FAIL manual_clamp: got %0d expected 8", gain); end
    if (state !== 2'd0) begin failures++; $display("FAIL manual_state: got %0d expected 0", state); end
    set_manual(3);
    for (int i = 0; i < 3; i++) push(100);
    release_run();
    for (int i = 0; i < 7; i++) begin
      push(100);
      checks++;
      if (gain !== 8'd3) begin failures++; $display("FAIL manual_release_early[%0d]: got %0d expected 3", i, gain); end
    end
    push(100);
    checks++;
    if (gain !== 8'd4) begin failures++; $display("FAIL manual_release_gain: got %0d expected 4", gain); end
  endtask

  task automatic test_enable_abort();
    set_manual(2);
    release_run();
    for (int i = 0; i < 5; i++) push(100);
    enable = 1'b0;
    m_active = 0;
    for (int i = 0; i < 3; i++) push(100);
    checks += 2;
    if (state !== 2'd0) begin failures++; $display("FAIL abort_state: got %0d expected 0", state); end
    if (gain !== 8'd2) begin failures++; $display("FAIL abort_gain: got %0d expected 2", gain); end
    release_run();
    for (int i = 0; i < 7; i++) push(100);
    checks++;
    if (gain !== 8'd2) begin failures++; $display("FAIL abort_partial: got %0d expected 2", gain); end
    push(100);
    checks++;
    if (gain !== 8'd3) begin failures++; $display("FAIL abort_full: got %0d expected 3", gain); end
  endtask

  task automatic test_random();
    int base, amp, v, cls, exp_state;
    set_manual(int'($urandom_range(0, 8)));
    release_run();
    base = pulse_cnt - m_pulses;
    amp = 100;
    for (int i = 0; i < 96; i++) begin
      if (i % 8 == 0) begin
        cls = int'($urandom_range(0, 2));
        amp = (cls == 0) ? int'($urandom_range(0, 511)) :
              (cls == 1) ? int'($urandom_range(512, 1535)) : int'($urandom_range(1536, 2047));
      end
      v = int'($urandom_range(0, amp));
      if ($urandom_range(0, 1) == 1) v = -v;
      if (cls == 2 && $urandom_range(0, 15) == 0) v = -2048;
      push(v);
      exp_state = (m_hold > 0) ? 3 : 1;
      checks += 3;
      if (gain !== GW'(m_gain)) begin failures++; $display("FAIL rand_gain[%0d]: got %0d expected %0d", i, gain, m_gain); end
      if (peak !== (DW-1)'(m_last_peak)) begin failures++; $display("FAIL rand_peak[%0d]: got %0d expected %0d", i, peak, m_last_peak); end
      if (state !== 2'(exp_state)) begin failures++; $display("FAIL rand_state[%0d]: got %0d expected %0d", i, state, exp_state); end
    end
    checks++;
    if (pulse_cnt - base !== m_pulses) begin failures++; $display("FAIL rand_pulses: got %0d expected %0d", pulse_cnt - base, m_pulses); end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 3; i++) push(100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (gain !== 8'd0) begin failures++; $display("FAIL midreset_gain: got %0d expected 0", gain); end
    if (peak !== 11'd0) begin failures++; $display("FAIL midreset_peak: got %0d expected 0", peak); end
    if (state !== 2'd0) begin failures++; $display("FAIL midreset_state: got %0d expected 0", state); end
    if (gain_changed !== 1'b0) begin failures++; $display("FAIL midreset_pulse: got %0b expected 0", gain_changed); end
  endtask

  initial begin
    test_reset();
    test_low_signal();
    test_overload();
    test_inband();
    test_saturation();
    test_manual();
    test_enable_abort();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
